spi_minion_frontend: RTL
========================

SPI_MINION_FRONTEND -- requirements
Module: spi_minion_frontend

Interface
REQ-001 The module SHALL have parameter NBITS, default 32, giving the SPI frame and packet width in bits (legal range 8..64).
REQ-002 The module SHALL have input clk, 1 bit: the single system clock; every flop is in this domain.
REQ-003 The module SHALL have input reset, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have input cs, 1 bit: SPI chip select from the pad, active-low and asynchronous to clk.
REQ-005 The module SHALL have input sclk, 1 bit: SPI clock from the pad (mode 0), asynchronous to clk.
REQ-006 The module SHALL have input mosi, 1 bit: SPI serial data in from the pad, MSB first.
REQ-007 The module SHALL have output miso, 1 bit: SPI serial data out, MSB first.
REQ-008 The module SHALL have outputs recv_msg (NBITS), recv_val (1) and input recv_rdy (1): the received packet toward the interconnect.
REQ-009 The module SHALL have inputs send_msg (NBITS), send_val (1) and output send_rdy (1): the reply packet from the interconnect.
REQ-010 The module SHALL have output parity, 1 bit: XOR reduction of recv_msg.
REQ-011 The module SHALL have outputs frame_err (1) and overflow (1), both sticky, and input err_clr (1), which clears both.

Function
REQ-012 cs, sclk and mosi SHALL each pass through a 2-flop synchronizer; cs and sclk SHALL each get a third flop for edge detection, giving 3 clk cycles of input latency.
REQ-013 The pads SHALL hold each sclk phase for at least 3 clk cycles and the cs setup/hold to sclk for at least 3 clk cycles; behaviour outside this is undefined.
REQ-014 The synchronized cs SHALL drive two states: IDLE (cs high) and ACTIVE (cs low).
REQ-015 A cs fall (IDLE->ACTIVE) SHALL clear bitcnt and load tx_shift as follows: from tx_buf if tx_full, then clear tx_full; otherwise with all zeros.
REQ-016 On a synchronized sclk rising edge in ACTIVE, rx_shift SHALL become {rx_shift[NBITS-2:0], mosi_sync}, and bitcnt SHALL increment, saturating at NBITS+1.
REQ-017 On a synchronized sclk falling edge in ACTIVE, tx_shift SHALL shift left by one with zero fill.
REQ-018 miso SHALL equal tx_shift[NBITS-1] in ACTIVE and 0 in IDLE.
REQ-019 On a cs rise (ACTIVE->IDLE) with bitcnt==NBITS, rx_shift SHALL be written to rx_buf and rx_full set, unless rx_full stays set that cycle.
REQ-020 In that case (rx_full and not recv_rdy), the frame SHALL be dropped, overflow set, and rx_buf left unchanged.
REQ-021 On a cs rise with bitcnt!=NBITS (short or long frame), frame_err SHALL be set, and rx_buf/rx_full SHALL be unchanged.
REQ-022 recv_val SHALL equal rx_full and recv_msg SHALL equal rx_buf; recv_val&&recv_rdy SHALL clear rx_full next cycle.
REQ-023 A recv handshake in the same cycle as a valid cs rise SHALL store the new frame with rx_full staying 1 and no overflow.
REQ-024 send_rdy SHALL equal !tx_full; send_val&&send_rdy SHALL load tx_buf and set tx_full.
REQ-025 A send handshake in the same cycle as a cs fall SHALL NOT affect that frame; the new tx_buf is used on the next frame.
REQ-026 err_clr SHALL clear frame_err/overflow next cycle; a set condition in the same cycle SHALL take priority over the clear.
REQ-027 recv_val SHALL assert 1 clk cycle after the synchronized cs rise, 4 clk cycles after the pad cs rise.

Reset
REQ-028 Reset SHALL asynchronously force the synchronizer flops to cs=1, sclk=0, mosi=0 and the state to IDLE.
REQ-029 Reset SHALL also force bitcnt=0, rx_shift=tx_shift=rx_buf=tx_buf=0 and rx_full=tx_full=0.
REQ-030 Outputs during reset SHALL be: miso=0, recv_val=0, recv_msg=0, send_rdy=0, parity=0, frame_err=0, overflow=0; send_rdy SHALL be 1 from the first cycle after reset deasserts.
REQ-031 Reset mid-frame SHALL discard the partial frame; the first full frame after cs returns high then low SHALL be received normally.

Configuration
REQ-032 With SPI_MINION_PARITY_EN defined, parity SHALL be ^rx_buf while rx_full and 0 otherwise; without it, parity SHALL be tied to 0 and no XOR logic synthesized.

Verification
REQ-033 Clock 10 ns and sclk 80 ns; frame 0xA5A51234 with recv_rdy=1 -> recv_msg=0xA5A51234, recv_val pulses 1 cycle, parity=1 (PARITY_EN).
REQ-034 send_msg=0xDEADBEEF handshaked before cs fall -> the 32 miso bits sampled on sclk rises equal 0xDEADBEEF MSB first; send_rdy=1 after cs fall.
REQ-035 Frame of 10 bits only -> frame_err=1, recv_val stays 0; err_clr pulse -> frame_err=0.
REQ-036 Two frames 0x00000001 then 0x00000002 with recv_rdy=0 -> recv_msg=0x00000001, overflow=1; the second frame is lost.
REQ-037 reset asserted after 16 bits of a frame -> all outputs at reset values; the next frame 0x12345678 is received as 0x12345678 with frame_err=0.
REQ-038 recv_rdy=1 pulse coinciding with the cs rise of frame 0xCAFEF00D while 0x11111111 is held -> recv_msg=0xCAFEF00D, recv_val=1, overflow=0.

Source files
------------

// File: rtl/spi_minion_frontend.sv
// rtl/spi_minion_frontend.sv - SPI mode-0 minion front end bridging pad SPI frames to valid/ready packets
//
// Purpose:
//   Receives fixed-width SPI frames (MSB first) into a one-entry receive buffer
//   and shifts out a one-entry reply buffer on miso during the next frame.
//   All pad inputs are asynchronous and are synchronized into clk.
//
// Ports:
//   clk        system clock, every flop lives here
//   reset      asynchronous active-high reset
//   cs         pad chip select, active-low, asynchronous
//   sclk       pad SPI clock (mode 0), asynchronous
//   mosi       pad serial data in, MSB first
//   miso       serial data out, MSB first, 0 while not selected
//   recv_msg   received packet (NBITS), recv_val / recv_rdy handshake
//   send_msg   reply packet (NBITS), send_val / send_rdy handshake
//   parity     XOR reduction of the held received packet (optional)
//   frame_err  sticky: frame ended with a bit count other than NBITS
//   overflow   sticky: complete frame dropped because rx buffer was full
//   err_clr    clears frame_err and overflow
//
// Configuration macro:
//   SPI_MINION_PARITY_EN  when defined, parity = ^recv_msg while recv_val;
//                         otherwise parity is tied to 0.

module spi_minion_frontend #(
    parameter int NBITS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             sclk,
    input  logic             mosi,
    output logic             miso,
    output logic [NBITS-1:0] recv_msg,
    output logic             recv_val,
    input  logic             recv_rdy,
    input  logic [NBITS-1:0] send_msg,
    input  logic             send_val,
    output logic             send_rdy,
    output logic             parity,
    output logic             frame_err,
    output logic             overflow,
    input  logic             err_clr
);

    localparam int CW = $clog2(NBITS + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(NBITS);
    localparam logic [CW-1:0] CNT_SAT  = CW'(NBITS + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t state_q;

    logic cs_s1_q, cs_s2_q, cs_s3_q;
    logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic mosi_s1_q, mosi_s2_q;

    logic [CW-1:0]    bitcnt_q;
    logic [NBITS-1:0] rx_shift_q;
    logic [NBITS-1:0] tx_shift_q;
    logic [NBITS-1:0] rx_buf_q;
    logic [NBITS-1:0] tx_buf_q;
    logic             rx_full_q;
    logic             tx_full_q;
    logic             frame_err_q;
    logic             overflow_q;
    // Holds send_rdy low during reset; rises on the first clock after release.
    logic             out_en_q;

    logic cs_fall, cs_rise, sclk_rise, sclk_fall;
    logic recv_fire, send_fire;
    logic frame_ok, frame_bad, frame_drop;
    logic frame_err_d, overflow_d;

    // cs edges compare the third synchronizer stage against the FSM state,
    // so the state register itself acts as the edge-detect memory.
    assign cs_fall   = (state_q == IDLE) && !cs_s3_q;
    assign cs_rise   = (state_q == ACTIVE) && cs_s3_q;
    assign sclk_rise = sclk_s2_q && !sclk_s3_q;
    assign sclk_fall = !sclk_s2_q && sclk_s3_q;

    assign recv_fire = rx_full_q && recv_rdy;
    assign send_fire = send_val && send_rdy;

    assign frame_ok   = cs_rise && (bitcnt_q == CNT_FULL);
    assign frame_bad  = cs_rise && (bitcnt_q != CNT_FULL);
    // A consumer draining the buffer in the same cycle frees the slot.
    assign frame_drop = frame_ok && rx_full_q && !recv_rdy;

    // Set beats clear when both happen in one cycle.
    assign frame_err_d = frame_bad  || (frame_err_q && !err_clr);
    assign overflow_d  = frame_drop || (overflow_q  && !err_clr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cs_s1_q     <= 1'b1;
            cs_s2_q     <= 1'b1;
            cs_s3_q     <= 1'b1;
            sclk_s1_q   <= 1'b0;
            sclk_s2_q   <= 1'b0;
            sclk_s3_q   <= 1'b0;
            mosi_s1_q   <= 1'b0;
            mosi_s2_q   <= 1'b0;
            bitcnt_q    <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            rx_buf_q    <= '0;
            tx_buf_q    <= '0;
            rx_full_q   <= 1'b0;
            tx_full_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            out_en_q    <= 1'b0;
        end else begin
            cs_s1_q   <= cs;
            cs_s2_q   <= cs_s1_q;
            cs_s3_q   <= cs_s2_q;
            sclk_s1_q <= sclk;
            sclk_s2_q <= sclk_s1_q;
            sclk_s3_q <= sclk_s2_q;
            mosi_s1_q <= mosi;
            mosi_s2_q <= mosi_s1_q;
            out_en_q  <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q    <= ACTIVE;
                        bitcnt_q   <= '0;
                        tx_shift_q <= tx_full_q ? tx_buf_q : '0;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state_q <= IDLE;
                    end else begin
                        if (sclk_rise) begin
                            rx_shift_q <= {rx_shift_q[NBITS-2:0], mosi_s2_q};
                            if (bitcnt_q != CNT_SAT) begin
                                bitcnt_q <= bitcnt_q + CW'(1);
                            end
                        end
                        if (sclk_fall) begin
                            tx_shift_q <= {tx_shift_q[NBITS-2:0], 1'b0};
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (frame_ok && !frame_drop) begin
                rx_buf_q  <= rx_shift_q;
                rx_full_q <= 1'b1;
            end else if (recv_fire) begin
                rx_full_q <= 1'b0;
            end

            // send_fire needs !tx_full, so it never collides with the unload.
            // A handshake during cs fall only lands in tx_buf for the next frame.
            if (cs_fall && tx_full_q) begin
                tx_full_q <= 1'b0;
            end else if (send_fire) begin
                tx_buf_q  <= send_msg;
                tx_full_q <= 1'b1;
            end

            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    assign miso      = (state_q == ACTIVE) ? tx_shift_q[NBITS-1] : 1'b0;
    assign recv_val  = rx_full_q;
    assign recv_msg  = rx_buf_q;
    assign send_rdy  = out_en_q && !tx_full_q;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

`ifdef SPI_MINION_PARITY_EN
    assign parity = rx_full_q && (^rx_buf_q);
`else
    assign parity = 1'b0;
`endif

endmodule
